// File: rtl/gpio_apb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_apb_arbiter_if
// Brief    : Requester-side command/response bundle plus the APB master bus
//            of the GPIO arbiter. The 'master' modport is the arbiter's view;
//            the 'slave' modport is the environment (requesters + GPIO slave).
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_apb_arbiter_if #(
  parameter int N_REQ          = 2,
  parameter int APB_ADDR_WIDTH = 12
);
  // Requester command side
  logic [N_REQ-1:0]                     req_i;
  logic [N_REQ-1:0][APB_ADDR_WIDTH-1:0] req_addr_i;
  logic [N_REQ-1:0][31:0]               req_wdata_i;
  logic [N_REQ-1:0]                     req_we_i;
  logic [N_REQ-1:0]                     gnt_o;

  // Requester response side
  logic [N_REQ-1:0]                     rsp_valid_o;
  logic [31:0]                          rsp_rdata_o;
  logic                                 rsp_err_o;
  logic                                 busy_o;

  // APB bus towards the GPIO slave
  logic [APB_ADDR_WIDTH-1:0]            PADDR;
  logic [31:0]                          PWDATA;
  logic                                 PWRITE;
  logic                                 PSEL;
  logic                                 PENABLE;
  logic [31:0]                          PRDATA;
  logic                                 PREADY;
  logic                                 PSLVERR;

  modport master (
    input  req_i, req_addr_i, req_wdata_i, req_we_i,
    input  PRDATA, PREADY, PSLVERR,
    output gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_i, req_addr_i, req_wdata_i, req_we_i,
    output PRDATA, PREADY, PSLVERR,
    input  gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface
`default_nettype wire

// File: rtl/gpio_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_apb_arbiter
// Brief    : Round-robin arbiter sharing one APB slave (GPIO) between N_REQ
//            single-word requesters. Sequences SETUP/ACCESS, absorbs the
//            slave's registered PRDATA latency, enforces an ACCESS timeout and
//            routes a one-cycle response back to the originating requester.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_apb_arbiter #(
  parameter int N_REQ          = 2,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int RDATA_LAT      = 1,
  parameter int TIMEOUT        = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  gpio_apb_arbiter_if.master  bus
);

  localparam int PTR_W = $clog2(N_REQ);
  // Counter only has to reach TIMEOUT-1
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RDWAIT = 2'd3
  } state_t;

  state_t                    r_state;
  logic [PTR_W-1:0]          r_ptr;
  logic [PTR_W-1:0]          r_id;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_slverr;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic [N_REQ-1:0]          r_rsp_valid;
  logic [31:0]               r_rsp_rdata;
  logic                      r_rsp_err;

  logic                      w_any;
  logic [PTR_W-1:0]          w_win;
  logic [N_REQ-1:0]          w_gnt;

  // (base + off) mod N_REQ without a divider; off is always < N_REQ
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin search: first active request at or after r_ptr
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_any && bus.req_i[wrap_idx(r_ptr, i)]) begin
        w_any = 1'b1;
        w_win = wrap_idx(r_ptr, i);
      end
    end
  end

  // Grant is combinational and only ever offered while idle
  always_comb begin
    w_gnt = '0;
    if (r_state == ST_IDLE && w_any) w_gnt[w_win] = 1'b1;
  end

  // Transfer sequencer; all APB and response outputs are registered here
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_slverr    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id      <= w_win;
            r_ptr     <= wrap_idx(w_win, 1);
            r_paddr   <= bus.req_addr_i[w_win];
            r_pwdata  <= bus.req_wdata_i[w_win];
            r_pwrite  <= bus.req_we_i[w_win];
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_slverr  <= bus.PSLVERR;
            if (r_pwrite || RDATA_LAT == 0) begin
              r_rsp_valid[r_id] <= 1'b1;
              r_rsp_rdata       <= r_pwrite ? 32'd0 : bus.PRDATA;
              r_rsp_err         <= bus.PSLVERR;
              r_state           <= ST_IDLE;
            end else begin
              // Registered-PRDATA slave: data shows up one cycle later
              r_state <= ST_RDWAIT;
            end
          end else if (TIMEOUT != 0 && r_cnt == C_TO_LAST) begin
            r_psel            <= 1'b0;
            r_penable         <= 1'b0;
            r_rsp_valid[r_id] <= 1'b1;
            r_rsp_rdata       <= 32'd0;
            r_rsp_err         <= 1'b1;
            r_state           <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RDWAIT: begin
          r_rsp_valid[r_id] <= 1'b1;
          r_rsp_rdata       <= bus.PRDATA;
          r_rsp_err         <= r_slverr;
          r_state           <= ST_IDLE;
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_o       = w_gnt;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_gpio_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_apb_arbiter
// Brief    : Directed self-checking bench for gpio_apb_arbiter with three
//            requesters, registered-PRDATA slave and a 4-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_apb_arbiter;

  logic HCLK;
  logic HRESET;
  int   n_cmp;
  int   n_err;

  gpio_apb_arbiter_if #(.N_REQ(3), .APB_ADDR_WIDTH(12)) bus ();

  gpio_apb_arbiter #(
    .N_REQ(3), .APB_ADDR_WIDTH(12), .RDATA_LAT(1), .TIMEOUT(4)
  ) u_dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    HRESET          = 1'b1;
    bus.req_i       = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_we_i    = '0;
    bus.PRDATA      = 32'hDEAD_BEEF;
    bus.PREADY      = 1'b1;
    bus.PSLVERR     = 1'b0;

    // ---------------- reset values ----------------
    cyc(); cyc(); settle();
    check("rst_psel",    32'(bus.PSEL),        32'd0);
    check("rst_penable", 32'(bus.PENABLE),     32'd0);
    check("rst_pwrite",  32'(bus.PWRITE),      32'd0);
    check("rst_paddr",   32'(bus.PADDR),       32'd0);
    check("rst_pwdata",  bus.PWDATA,           32'd0);
    check("rst_gnt",     32'(bus.gnt_o),       32'd0);
    check("rst_rspv",    32'(bus.rsp_valid_o), 32'd0);
    check("rst_rdata",   bus.rsp_rdata_o,      32'd0);
    check("rst_err",     32'(bus.rsp_err_o),   32'd0);
    check("rst_busy",    32'(bus.busy_o),      32'd0);
    HRESET = 1'b0;

    // ---------------- single write by req0 ----------------
    bus.req_i          = 3'b001;
    bus.req_we_i[0]    = 1'b1;
    bus.req_addr_i[0]  = 12'h000;
    bus.req_wdata_i[0] = 32'h0000_0005;
    settle();
    check("wr_gnt_c0", 32'(bus.gnt_o), 32'b001);
    cyc(); bus.req_i = '0; settle();
    check("wr_psel_c1",    32'(bus.PSEL),    32'd1);
    check("wr_penable_c1", 32'(bus.PENABLE), 32'd0);
    check("wr_pwdata_c1",  bus.PWDATA,       32'h5);
    check("wr_busy_c1",    32'(bus.busy_o),  32'd1);
    cyc(); settle();
    check("wr_penable_c2", 32'(bus.PENABLE), 32'd1);
    check("wr_paddr_c2",   32'(bus.PADDR),   32'h000);
    check("wr_pwrite_c2",  32'(bus.PWRITE),  32'd1);
    cyc(); settle();
    check("wr_rspv_c3",  32'(bus.rsp_valid_o), 32'b001);
    check("wr_rdata_c3", bus.rsp_rdata_o,      32'd0);
    check("wr_err_c3",   32'(bus.rsp_err_o),   32'd0);
    check("wr_psel_c3",  32'(bus.PSEL),        32'd0);
    check("wr_busy_c3",  32'(bus.busy_o),      32'd0);

    // ---------------- read by req1 with registered PRDATA ----------------
    bus.req_i         = 3'b010;
    bus.req_we_i[1]   = 1'b0;
    bus.req_addr_i[1] = 12'h034;
    settle();
    check("rd_gnt_c0", 32'(bus.gnt_o), 32'b010);
    cyc(); bus.req_i = '0; settle();
    check("rd_paddr_c1",  32'(bus.PADDR),  32'h034);
    check("rd_pwrite_c1", 32'(bus.PWRITE), 32'd0);
    cyc(); settle();
    check("rd_penable_c2", 32'(bus.PENABLE), 32'd1);
    cyc(); bus.PRDATA = 32'h0000_0203; settle();
    check("rd_psel_c3",    32'(bus.PSEL),        32'd0);
    check("rd_penable_c3", 32'(bus.PENABLE),     32'd0);
    check("rd_rspv_c3",    32'(bus.rsp_valid_o), 32'd0);
    check("rd_busy_c3",    32'(bus.busy_o),      32'd1);
    cyc(); bus.PRDATA = 32'hDEAD_BEEF; settle();
    check("rd_rspv_c4",  32'(bus.rsp_valid_o), 32'b010);
    check("rd_rdata_c4", bus.rsp_rdata_o,      32'h0000_0203);
    check("rd_err_c4",   32'(bus.rsp_err_o),   32'd0);

    // ---------------- contention: all three requesting from reset ----------------
    HRESET = 1'b1;
    bus.req_i    = 3'b111;
    bus.req_we_i = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr_i[i]  = 12'(16 * i);
      bus.req_wdata_i[i] = 32'hA0 + 32'(i);
    end
    cyc(); cyc(); HRESET = 1'b0; settle();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_gnt_%0d", k), 32'(bus.gnt_o), 32'd1 << (k % 3));
      if (k > 0)
        check($sformatf("rr_rspv_%0d", k), 32'(bus.rsp_valid_o), 32'd1 << ((k - 1) % 3));
      cyc(); settle();
      check($sformatf("rr_pwdata_%0d", k), bus.PWDATA, 32'hA0 + 32'(k % 3));
      check($sformatf("rr_nognt_%0d", k), 32'(bus.gnt_o), 32'd0);
      cyc(); cyc(); settle();
    end
    bus.req_i = '0; settle();
    check("rr_rspv_last", 32'(bus.rsp_valid_o), 32'b100);
    check("rr_gnt_last",  32'(bus.gnt_o),       32'd0);

    // ---------------- wait states then PSLVERR (req0 write) ----------------
    cyc();
    bus.req_i = 3'b001; bus.req_wdata_i[0] = 32'h77; bus.PREADY = 1'b0; settle();
    check("ws_gnt_c0", 32'(bus.gnt_o), 32'b001);
    cyc(); bus.req_i = '0;
    cyc(); cyc(); cyc(); settle();
    check("ws_psel_c4",    32'(bus.PSEL),        32'd1);
    check("ws_penable_c4", 32'(bus.PENABLE),     32'd1);
    check("ws_rspv_c4",    32'(bus.rsp_valid_o), 32'd0);
    cyc(); bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; settle();
    check("ws_rspv_c5", 32'(bus.rsp_valid_o), 32'd0);
    cyc(); bus.PSLVERR = 1'b0; settle();
    check("ws_rspv_c6", 32'(bus.rsp_valid_o), 32'b001);
    check("ws_err_c6",  32'(bus.rsp_err_o),   32'd1);
    check("ws_busy_c6", 32'(bus.busy_o),      32'd0);

    // ---------------- timeout on req1 read, req2 queued behind it ----------------
    cyc();
    bus.req_i = 3'b010; bus.req_we_i[1] = 1'b0; bus.PREADY = 1'b0; settle();
    check("to_gnt_c0", 32'(bus.gnt_o), 32'b010);
    cyc();
    bus.req_i = 3'b100; bus.req_we_i[2] = 1'b1; bus.req_wdata_i[2] = 32'h55; settle();
    check("to_ignored_c1", 32'(bus.gnt_o), 32'd0);
    cyc(); cyc(); cyc(); cyc(); settle();
    check("to_psel_c5",    32'(bus.PSEL),    32'd1);
    check("to_penable_c5", 32'(bus.PENABLE), 32'd1);
    cyc(); settle();
    check("to_psel_c6",  32'(bus.PSEL),        32'd0);
    check("to_rspv_c6",  32'(bus.rsp_valid_o), 32'b010);
    check("to_err_c6",   32'(bus.rsp_err_o),   32'd1);
    check("to_rdata_c6", bus.rsp_rdata_o,      32'd0);
    check("to_gnt_c6",   32'(bus.gnt_o),       32'b100);
    bus.PREADY = 1'b1;
    cyc(); bus.req_i = '0; settle();
    check("to_next_pwdata", bus.PWDATA,          32'h55);
    check("to_next_pwrite", 32'(bus.PWRITE),     32'd1);
    cyc(); cyc(); settle();
    check("to_next_rspv", 32'(bus.rsp_valid_o), 32'b100);
    check("to_next_err",  32'(bus.rsp_err_o),   32'd0);

    // ---------------- reset in the middle of ACCESS ----------------
    cyc();
    bus.req_i = 3'b001; bus.PREADY = 1'b0; settle();
    check("mr_gnt_c0", 32'(bus.gnt_o), 32'b001);
    cyc(); bus.req_i = '0;
    cyc(); settle();
    check("mr_psel_c2", 32'(bus.PSEL), 32'd1);
    #2 HRESET = 1'b1;
    settle();
    check("mr_psel_async",    32'(bus.PSEL),    32'd0);
    check("mr_penable_async", 32'(bus.PENABLE), 32'd0);
    check("mr_busy_async",    32'(bus.busy_o),  32'd0);
    cyc(); cyc();
    HRESET = 1'b0;
    bus.PREADY = 1'b1;
    bus.req_i = 3'b011;
    settle();
    check("mr_rspv_after", 32'(bus.rsp_valid_o), 32'd0);
    check("mr_gnt_after",  32'(bus.gnt_o),       32'b001);
    cyc(); bus.req_i = '0; settle();
    check("mr_rspv_next", 32'(bus.rsp_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
